stage_sequencer: RTL and testbench

//  Multi-cycle controller for the single-issue core: steps one instruction at a time

---
 rtl/stage_sequencer_pkg.sv | 22 ++
 rtl/stage_sequencer_fetch_timeout.sv | 29 ++
 rtl/stage_sequencer.sv | 140 ++++++++++++++
 tb/tb_stage_sequencer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stage_sequencer_pkg.sv
// Shared types for the multi-cycle stage sequencer: FSM states, fault codes, PC step.
package stage_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        WB,
        HALT
    } seq_state_t;

    typedef enum logic [1:0] {
        FAULT_NONE,
        FAULT_ILLEGAL,
        FAULT_TIMEOUT,
        FAULT_MISALIGN
    } fault_t;

    localparam logic [31:0] PC_STEP = 32'h4;

endpackage

// File: rtl/stage_sequencer_fetch_timeout.sv
// Counts FETCH cycles without an instruction-memory ack; expired marks the last allowed cycle.
module fetch_timeout_counter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned W = $clog2(TIMEOUT) + 1;

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (enable_i && !expired_o) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    // Count k-1 during the k-th FETCH cycle, so expiry flags the TIMEOUT-th cycle itself.
    assign expired_o = (cnt_q == W'(TIMEOUT - 1));

endmodule

// File: rtl/stage_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/WB controller: owns the PC, drives the imem handshake,
// applies redirects, counts retirements and halts with a sticky fault code.
module stage_sequencer
    import stage_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned IMEM_TIMEOUT = 16,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      inst,
    input  logic             decode_illegal,
    input  logic             stall,
    output logic             exec_en,
    input  logic             exec_pc_update,
    input  logic [31:0]      exec_next_pc,
    output logic             wb_en,
    output logic [31:0]      pc,
    output logic [CNT_W-1:0] retire_count,
    output logic             halt,
    output logic [1:0]       fault_code
);

    seq_state_t       state_q, state_d;
    fault_t           fault_q, fault_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      inst_q, inst_d;
    logic [31:0]      tgt_q, tgt_d;
    logic             upd_q, upd_d;
    logic [CNT_W-1:0] retire_q, retire_d;
    logic             tmo_expired;

    fetch_timeout_counter #(
        .TIMEOUT (IMEM_TIMEOUT)
    ) u_fetch_timeout (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (state_q != FETCH),
        .enable_i  ((state_q == FETCH) && !imem_ack),
        .expired_o (tmo_expired)
    );

    always_comb begin
        state_d  = state_q;
        fault_d  = fault_q;
        pc_d     = pc_q;
        inst_d   = inst_q;
        tgt_d    = tgt_q;
        upd_d    = upd_q;
        retire_d = retire_q;

        unique case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                // An ack arriving on the final allowed cycle still wins over the timeout.
                if (imem_ack) begin
                    inst_d  = imem_rdata;
                    state_d = DECODE;
                end else if (tmo_expired) begin
                    fault_d = FAULT_TIMEOUT;
                    state_d = HALT;
                end
            end
            DECODE: begin
                if (!stall) begin
                    if (decode_illegal) begin
                        fault_d = FAULT_ILLEGAL;
                        state_d = HALT;
                    end else begin
                        state_d = EXEC;
                    end
                end
            end
            EXEC: begin
                if (!stall) begin
                    upd_d   = exec_pc_update;
                    tgt_d   = exec_next_pc & 32'hFFFF_FFFE;
                    state_d = WB;
                end
            end
            WB: begin
                if (!stall) begin
                    retire_d = retire_q + CNT_W'(1);
                    // A redirect to a non-word-aligned target retires but leaves pc alone.
                    if (upd_q && tgt_q[1]) begin
                        fault_d = FAULT_MISALIGN;
                        state_d = HALT;
                    end else begin
                        pc_d    = upd_q ? tgt_q : pc_q + PC_STEP;
                        state_d = FETCH;
                    end
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            fault_q  <= FAULT_NONE;
            pc_q     <= RESET_PC;
            inst_q   <= '0;
            tgt_q    <= '0;
            upd_q    <= 1'b0;
            retire_q <= '0;
        end else begin
            state_q  <= state_d;
            fault_q  <= fault_d;
            pc_q     <= pc_d;
            inst_q   <= inst_d;
            tgt_q    <= tgt_d;
            upd_q    <= upd_d;
            retire_q <= retire_d;
        end
    end

    assign imem_req     = (state_q == FETCH);
    assign imem_addr    = pc_q;
    assign inst         = inst_q;
    assign exec_en      = (state_q == EXEC) && !stall;
    assign wb_en        = (state_q == WB) && !stall;
    assign pc           = pc_q;
    assign retire_count = retire_q;
    assign halt         = (state_q == HALT);
    assign fault_code   = fault_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer: sequencing, redirects, faults, stalls, wrap and reset.
module tb_stage_sequencer;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic        decode_illegal;
    logic        stall;
    logic        exec_en;
    logic        exec_pc_update;
    logic [31:0] exec_next_pc;
    logic        wb_en;
    logic [31:0] pc;
    logic [31:0] retire_count;
    logic        halt;
    logic [1:0]  fault_code;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int req_cyc = 0;
    int exec_pulses = 0;
    int wb_pulses   = 0;

    stage_sequencer #(
        .RESET_PC     (32'h0000_0000),
        .IMEM_TIMEOUT (16),
        .CNT_W        (32)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .inst           (inst),
        .decode_illegal (decode_illegal),
        .stall          (stall),
        .exec_en        (exec_en),
        .exec_pc_update (exec_pc_update),
        .exec_next_pc   (exec_next_pc),
        .wb_en          (wb_en),
        .pc             (pc),
        .retire_count   (retire_count),
        .halt           (halt),
        .fault_code     (fault_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Strobe pulse counters, sampled mid-low-phase after inputs have settled.
    always @(negedge clk) begin
        #2;
        if (exec_en) exec_pulses++;
        if (wb_en)   wb_pulses++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        imem_ack = 1'b0; imem_rdata = '0; decode_illegal = 1'b0;
        stall = 1'b0; exec_pc_update = 1'b0; exec_next_pc = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic wait_req();
        int n = 0;
        while (!imem_req && n < 40) begin
            @(negedge clk); #1;
            n++;
        end
        check("imem_req_wait", imem_req, 1);
        req_cyc = cyc;
    endtask

    // Walk one instruction through all stages; returns at negedge+1 of the following state.
    task automatic do_inst(input logic [31:0] exp_addr, input logic [31:0] word, input int ack_dly,
                           input logic illegal, input logic upd, input logic [31:0] npc,
                           input int st_e, input int st_w);
        wait_req();
        check("imem_addr", imem_addr, exp_addr);
        repeat (ack_dly) @(negedge clk);
        imem_ack = 1'b1; imem_rdata = word;
        @(negedge clk);
        imem_ack = 1'b0; decode_illegal = illegal;
        #1 check("inst", inst, word);
        @(negedge clk);
        decode_illegal = 1'b0;
        if (illegal) begin
            #1;
            return;
        end
        repeat (st_e) begin
            stall = 1'b1;
            #1 check("exec_en_stalled", exec_en, 0);
            @(negedge clk);
        end
        stall = 1'b0; exec_pc_update = upd; exec_next_pc = npc;
        #1 check("exec_en", exec_en, 1);
        @(negedge clk);
        exec_pc_update = 1'b0; exec_next_pc = '0;
        repeat (st_w) begin
            stall = 1'b1;
            #1 check("wb_en_stalled", wb_en, 0);
            @(negedge clk);
        end
        stall = 1'b0;
        #1 check("wb_en", wb_en, 1);
        @(negedge clk); #1;
    endtask

    initial begin
        int c1, e0, w0;
        rst = 1'b0;
        imem_ack = 1'b0; imem_rdata = '0; decode_illegal = 1'b0;
        stall = 1'b0; exec_pc_update = 1'b0; exec_next_pc = '0;
        #2 rst = 1'b1;
        #1;
        check("rst_pc", pc, 32'h0);
        check("rst_inst", inst, 32'h0);
        check("rst_retire", retire_count, 0);
        check("rst_halt", halt, 0);
        check("rst_fault", fault_code, 0);
        check("rst_req", imem_req, 0);
        check("rst_strobes", {exec_en, wb_en}, 0);
        apply_reset();

        // Three sequential instructions, ack in the second FETCH cycle.
        e0 = exec_pulses; w0 = wb_pulses;
        do_inst(32'h0, 32'h1111_0001, 1, 0, 0, 32'h0, 0, 0);
        c1 = req_cyc;
        do_inst(32'h4, 32'h1111_0002, 1, 0, 0, 32'h0, 0, 0);
        check("cycles_per_inst", req_cyc - c1, 5);
        do_inst(32'h8, 32'h1111_0003, 1, 0, 0, 32'h0, 0, 0);
        check("t1_retire", retire_count, 3);
        check("t1_exec_pulses", exec_pulses - e0, 3);
        check("t1_wb_pulses", wb_pulses - w0, 3);
        check("t1_pc", pc, 32'hC);

        // Redirect with bit0 masked, then misaligned redirect.
        do_inst(32'hC, 32'h2222_0001, 1, 0, 1, 32'h0000_0101, 0, 0);
        check("t2_pc_redirect", pc, 32'h100);
        do_inst(32'h100, 32'h2222_0002, 1, 0, 1, 32'h0000_0102, 0, 0);
        check("t2_halt", halt, 1);
        check("t2_fault", fault_code, 3);
        check("t2_retire", retire_count, 5);
        check("t2_pc_hold", pc, 32'h100);
        check("t2_req", imem_req, 0);

        // Fetch timeout after 16 cycles without ack.
        apply_reset();
        wait_req();
        repeat (15) @(negedge clk);
        #1;
        check("t3_req_cycle16", imem_req, 1);
        check("t3_halt_cycle16", halt, 0);
        @(negedge clk); #1;
        check("t3_halt", halt, 1);
        check("t3_fault", fault_code, 2);
        check("t3_req", imem_req, 0);

        // Ack on the 16th cycle wins over timeout.
        apply_reset();
        do_inst(32'h0, 32'h3333_0001, 15, 0, 0, 32'h0, 0, 0);
        check("t3b_halt", halt, 0);
        check("t3b_retire", retire_count, 1);
        check("t3b_pc", pc, 32'h4);

        // Illegal instruction on the second fetch.
        apply_reset();
        do_inst(32'h0, 32'h4444_0001, 1, 0, 0, 32'h0, 0, 0);
        do_inst(32'h4, 32'h4444_0002, 1, 1, 0, 32'h0, 0, 0);
        check("t4_halt", halt, 1);
        check("t4_fault", fault_code, 1);
        check("t4_retire", retire_count, 1);
        check("t4_pc", pc, 32'h4);
        e0 = exec_pulses; w0 = wb_pulses;
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; stall = 1'b1;
        repeat (4) @(negedge clk);
        imem_ack = 1'b0; stall = 1'b0;
        #1;
        check("t4_halt_sticky", halt, 1);
        check("t4_inst_hold", inst, 32'h4444_0002);
        check("t4_retire_hold", retire_count, 1);
        check("t4_req_off", imem_req, 0);
        check("t4_no_strobes", (exec_pulses - e0) + (wb_pulses - w0), 0);

        // Stalls in EXEC and WB delay but never drop strobes.
        apply_reset();
        e0 = exec_pulses; w0 = wb_pulses;
        do_inst(32'h0, 32'h5555_0001, 1, 0, 0, 32'h0, 3, 3);
        check("t5_exec_pulses", exec_pulses - e0, 1);
        check("t5_wb_pulses", wb_pulses - w0, 1);
        check("t5_pc", pc, 32'h4);
        check("t5_retire", retire_count, 1);

        // PC wrap past 2^32, then reset in the middle of FETCH.
        apply_reset();
        do_inst(32'h0, 32'h6666_0001, 0, 0, 1, 32'hFFFF_FFFC, 0, 0);
        check("t6_pc_top", pc, 32'hFFFF_FFFC);
        do_inst(32'hFFFF_FFFC, 32'h6666_0002, 0, 0, 0, 32'h0, 0, 0);
        check("t6_pc_wrap", pc, 32'h0);
        do_inst(32'h0, 32'h6666_0003, 1, 0, 0, 32'h0, 0, 0);
        check("t6_retire", retire_count, 3);
        wait_req();
        rst = 1'b1;
        #1;
        check("t6_rst_req", imem_req, 0);
        check("t6_rst_pc", pc, 32'h0);
        check("t6_rst_retire", retire_count, 0);
        check("t6_rst_inst", inst, 32'h0);
        @(negedge clk);
        rst = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h7777_7777;
        @(negedge clk);
        imem_ack = 1'b0;
        #1;
        check("t6_late_ack_inst", inst, 32'h0);
        check("t6_fetch_after_idle", imem_req, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
